// File: rtl/otter_pkg.sv
// Otter core shared definitions: next-PC select codes,
// fetch sequencer states and instruction alignment mask.
package otter_pkg;

  typedef enum logic [2:0] {
    PC_PLUS4  = 3'd0,
    PC_JALR   = 3'd1,
    PC_BRANCH = 3'd2,
    PC_JAL    = 3'd3,
    PC_MTVEC  = 3'd4,
    PC_MEPC   = 3'd5
  } pc_sel_e;

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2,
    ST_EXEC  = 2'd3
  } fetch_state_e;

  localparam logic [31:0] INSTR_ALIGN_MASK = 32'h3;

endpackage

// File: rtl/pc_target_mux.sv
// Next-PC target selection with jalr/mtvec alignment
// and misaligned control-transfer detection.
module pc_target_mux
  import otter_pkg::*;
(
  input  logic [2:0]  i_pc_sel,
  input  logic [31:0] i_pc_plus4,
  input  logic [31:0] i_jal_addr,
  input  logic [31:0] i_branch_addr,
  input  logic [31:0] i_jalr_addr,
  input  logic [31:0] i_mtvec,
  input  logic [31:0] i_mepc,
  output logic [31:0] o_target,
  output logic [31:0] o_mtvec_tgt,
  output logic        o_misaligned
);

  logic w_chk;

  // Direct-mode trap vector only: mode bits are dropped.
  assign o_mtvec_tgt = i_mtvec & ~INSTR_ALIGN_MASK;

  always_comb begin
    o_target = i_pc_plus4;
    w_chk    = 1'b0;
    case (i_pc_sel)
      PC_JALR: begin
        o_target = {i_jalr_addr[31:1], 1'b0};
        w_chk    = 1'b1;
      end
      PC_BRANCH: begin
        o_target = i_branch_addr;
        w_chk    = 1'b1;
      end
      PC_JAL: begin
        o_target = i_jal_addr;
        w_chk    = 1'b1;
      end
      PC_MTVEC: o_target = o_mtvec_tgt;
      PC_MEPC: begin
        o_target = i_mepc;
        w_chk    = 1'b1;
      end
      default: o_target = i_pc_plus4;
    endcase
  end

  assign o_misaligned =
    w_chk && (|(o_target & INSTR_ALIGN_MASK));

endmodule

// File: rtl/pc_sequencer.sv
// Otter PC register and instruction-fetch sequencer with
// req/ack fetch, valid/ready decode handoff and misalign trap.
module pc_sequencer
  import otter_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pc_write,
  input  logic [2:0]  pc_sel,
  input  logic [31:0] jal_addr,
  input  logic [31:0] branch_addr,
  input  logic [31:0] jalr_addr,
  input  logic [31:0] mtvec,
  input  logic [31:0] mepc,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ir,
  output logic        ir_valid,
  input  logic        ir_ready,
  output logic        misalign_trap,
  output logic [31:0] misalign_addr
);

  fetch_state_e r_state;
  fetch_state_e w_next;

  logic [31:0] r_pc;
  logic [31:0] r_ir;
  logic        r_trap;
  logic [31:0] r_maddr;

  logic [31:0] w_target;
  logic [31:0] w_mtvec_tgt;
  logic        w_misaligned;
  logic        w_commit;
  logic        w_load_ir;

  pc_target_mux u_mux (
    .i_pc_sel      (pc_sel),
    .i_pc_plus4    (pc_plus4),
    .i_jal_addr    (jal_addr),
    .i_branch_addr (branch_addr),
    .i_jalr_addr   (jalr_addr),
    .i_mtvec       (mtvec),
    .i_mepc        (mepc),
    .o_target      (w_target),
    .o_mtvec_tgt   (w_mtvec_tgt),
    .o_misaligned  (w_misaligned)
  );

  always_comb begin
    w_next    = r_state;
    w_commit  = 1'b0;
    w_load_ir = 1'b0;
    case (r_state)
      ST_RESET: w_next = ST_FETCH;
      ST_FETCH: begin
        if (imem_ack) begin
          w_load_ir = 1'b1;
          w_next    = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (ir_ready && pc_write) begin
          w_commit = 1'b1;
          w_next   = ST_FETCH;
        end else if (ir_ready) begin
          w_next = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (pc_write) begin
          w_commit = 1'b1;
          w_next   = ST_FETCH;
        end
      end
      default: w_next = ST_RESET;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_RESET;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc    <= RESET_VECTOR;
      r_ir    <= 32'h0;
      r_trap  <= 1'b0;
      r_maddr <= 32'h0;
    end else begin
      r_trap <= 1'b0;
      if (w_load_ir) begin
        r_ir <= imem_rdata;
      end
      if (w_commit && w_misaligned) begin
        r_pc    <= w_mtvec_tgt;
        r_trap  <= 1'b1;
        r_maddr <= w_target;
      end else if (w_commit) begin
        r_pc <= w_target;
      end
    end
  end

  assign pc            = r_pc;
  assign pc_plus4      = r_pc + 32'd4;
  assign imem_req      = (r_state == ST_FETCH);
  assign imem_addr     = r_pc;
  assign ir            = r_ir;
  assign ir_valid      = (r_state == ST_HOLD);
  assign misalign_trap = r_trap;
  assign misalign_addr = r_maddr;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: directed stimulus queues
// expected snapshots and fetched words; a monitor compares.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        pc_write;
  logic [2:0]  pc_sel;
  logic [31:0] jal_addr, branch_addr, jalr_addr;
  logic [31:0] mtvec, mepc;
  logic [31:0] pc, pc_plus4;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] ir;
  logic        ir_valid;
  logic        ir_ready;
  logic        misalign_trap;
  logic [31:0] misalign_addr;

  pc_sequencer #(.RESET_VECTOR(32'h0)) dut (
    .clk           (clk),
    .rst           (rst),
    .pc_write      (pc_write),
    .pc_sel        (pc_sel),
    .jal_addr      (jal_addr),
    .branch_addr   (branch_addr),
    .jalr_addr     (jalr_addr),
    .mtvec         (mtvec),
    .mepc          (mepc),
    .pc            (pc),
    .pc_plus4      (pc_plus4),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .ir            (ir),
    .ir_valid      (ir_valid),
    .ir_ready      (ir_ready),
    .misalign_trap (misalign_trap),
    .misalign_addr (misalign_addr)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    int          cyc;
    logic [31:0] pc;
    logic [31:0] p4;
    logic        req;
    logic        valid;
    logic        trap;
    logic [31:0] maddr;
    logic        chk_ir;
    logic [31:0] ir;
  } exp_t;

  exp_t        expq[$];
  logic [31:0] irq[$];
  int          cyc = 0;
  int          n_chk = 0;
  int          n_pass = 0;
  logic        prev_valid = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_at(input string nm, input int d,
                           input logic [31:0] epc,
                           input logic [31:0] ep4,
                           input logic ereq, input logic eval,
                           input logic etrap,
                           input logic [31:0] emaddr,
                           input logic cir,
                           input logic [31:0] eir);
    exp_t e;
    e.name = nm; e.cyc = cyc + d; e.pc = epc; e.p4 = ep4;
    e.req = ereq; e.valid = eval; e.trap = etrap;
    e.maddr = emaddr; e.chk_ir = cir; e.ir = eir;
    expq.push_back(e);
  endtask

  task automatic do_ack(input logic [31:0] data);
    imem_ack = 1'b1;
    imem_rdata = data;
    irq.push_back(data);
    tick();
    imem_ack = 1'b0;
  endtask

  // Monitor: pops fetched-word queue on each new valid, and
  // compares timed state snapshots.
  always @(negedge clk) begin
    if (ir_valid && !prev_valid) begin
      n_chk++;
      if (irq.size() == 0) begin
        $display("FAIL ir_word: unexpected valid ir=%h", ir);
      end else begin
        logic [31:0] w;
        w = irq.pop_front();
        if (ir !== w)
          $display("FAIL ir_word: got %h want %h", ir, w);
        else
          n_pass++;
      end
    end
    prev_valid <= ir_valid;
    while (expq.size() > 0 && expq[0].cyc <= cyc) begin
      exp_t e;
      e = expq.pop_front();
      n_chk++;
      if (e.cyc != cyc ||
          pc !== e.pc || pc_plus4 !== e.p4 ||
          imem_req !== e.req || ir_valid !== e.valid ||
          misalign_trap !== e.trap ||
          misalign_addr !== e.maddr ||
          (e.req && imem_addr !== e.pc) ||
          (e.chk_ir && ir !== e.ir)) begin
        $display("FAIL %s: got pc=%h p4=%h req=%b addr=%h v=%b trap=%b ma=%h ir=%h want pc=%h p4=%h req=%b v=%b trap=%b ma=%h ir=%h",
                 e.name, pc, pc_plus4, imem_req, imem_addr, ir_valid,
                 misalign_trap, misalign_addr, ir, e.pc, e.p4,
                 e.req, e.valid, e.trap, e.maddr, e.ir);
      end else begin
        n_pass++;
      end
    end
  end

  initial begin
    rst = 1'b1; pc_write = 1'b0; pc_sel = 3'd0;
    jal_addr = 0; branch_addr = 0; jalr_addr = 0;
    mtvec = 32'h81; mepc = 0;
    imem_ack = 1'b0; imem_rdata = 0; ir_ready = 1'b0;
    tick(); tick();
    expect_at("reset", 0, 32'h0, 32'h4, 0, 0, 0, 0, 1, 32'h0);
    rst = 1'b0;
    expect_at("first_req", 1, 32'h0, 32'h4, 1, 0, 0, 0, 0, 0);
    tick();
    expect_at("wait1", 1, 32'h0, 32'h4, 1, 0, 0, 0, 0, 0);
    tick();
    expect_at("wait2", 1, 32'h0, 32'h4, 1, 0, 0, 0, 0, 0);
    tick();
    expect_at("hold0", 1, 32'h0, 32'h4, 0, 1, 0, 0, 1,
              32'h0050_0093);
    do_ack(32'h0050_0093);
    ir_ready = 1'b1; pc_write = 1'b1; pc_sel = 3'd0;
    expect_at("seq_pc4", 1, 32'h4, 32'h8, 1, 0, 0, 0, 0, 0);
    tick();
    ir_ready = 1'b0; pc_write = 1'b0;
    expect_at("same_ack", 1, 32'h4, 32'h8, 0, 1, 0, 0, 0, 0);
    do_ack(32'h11);
    ir_ready = 1'b1;
    expect_at("to_exec", 1, 32'h4, 32'h8, 0, 0, 0, 0, 1, 32'h11);
    tick();
    ir_ready = 1'b0;
    pc_write = 1'b1; pc_sel = 3'd3; jal_addr = 32'h100;
    expect_at("jal", 1, 32'h100, 32'h104, 1, 0, 0, 0, 0, 0);
    tick();
    jal_addr = 32'h200;
    expect_at("wr_in_fetch", 1, 32'h100, 32'h104, 1, 0, 0, 0,
              0, 0);
    tick();
    pc_write = 1'b0;
    do_ack(32'h22);
    pc_write = 1'b1;
    expect_at("wr_hold_norr", 1, 32'h100, 32'h104, 0, 1, 0, 0,
              1, 32'h22);
    tick();
    pc_write = 1'b0;
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    expect_at("stray_hold", 1, 32'h100, 32'h104, 0, 1, 0, 0,
              1, 32'h22);
    tick();
    imem_ack = 1'b0; ir_ready = 1'b1;
    tick();
    ir_ready = 1'b0;
    imem_ack = 1'b1;
    expect_at("stray_exec", 1, 32'h100, 32'h104, 0, 0, 0, 0,
              1, 32'h22);
    tick();
    imem_ack = 1'b0;
    pc_write = 1'b1; pc_sel = 3'd1; jalr_addr = 32'h203;
    expect_at("jalr_trap", 1, 32'h80, 32'h84, 1, 0, 1, 32'h202,
              0, 0);
    expect_at("trap_end", 2, 32'h80, 32'h84, 1, 0, 0, 32'h202,
              0, 0);
    tick();
    pc_write = 1'b0;
    tick();
    do_ack(32'h33);
    ir_ready = 1'b1; pc_write = 1'b1; pc_sel = 3'd3;
    jal_addr = 32'hFFFF_FFFC;
    expect_at("top_pc", 1, 32'hFFFF_FFFC, 32'h0, 1, 0, 0,
              32'h202, 0, 0);
    tick();
    ir_ready = 1'b0; pc_write = 1'b0;
    do_ack(32'h44);
    ir_ready = 1'b1; pc_write = 1'b1; pc_sel = 3'd0;
    expect_at("wrap", 1, 32'h0, 32'h4, 1, 0, 0, 32'h202, 0, 0);
    tick();
    ir_ready = 1'b0; pc_write = 1'b0;
    do_ack(32'h55);
    ir_ready = 1'b1; pc_write = 1'b1; pc_sel = 3'd5;
    mepc = 32'h400;
    expect_at("mepc", 1, 32'h400, 32'h404, 1, 0, 0, 32'h202,
              0, 0);
    tick();
    ir_ready = 1'b0; pc_write = 1'b0;
    do_ack(32'h66);
    ir_ready = 1'b1; pc_write = 1'b1; pc_sel = 3'd2;
    branch_addr = 32'h502; mtvec = 32'h1003;
    expect_at("br_trap", 1, 32'h1000, 32'h1004, 1, 0, 1,
              32'h502, 0, 0);
    tick();
    ir_ready = 1'b0; pc_write = 1'b0;
    do_ack(32'h77);
    ir_ready = 1'b1; pc_write = 1'b1; pc_sel = 3'd7;
    expect_at("sel7", 1, 32'h1004, 32'h1008, 1, 0, 0, 32'h502,
              0, 0);
    tick();
    ir_ready = 1'b0; pc_write = 1'b0;
    rst = 1'b1; imem_ack = 1'b1; imem_rdata = 32'h99;
    pc_write = 1'b1;
    expect_at("rst_fetch", 1, 32'h0, 32'h4, 0, 0, 0, 0, 1, 32'h0);
    tick();
    rst = 1'b0; imem_ack = 1'b0; pc_write = 1'b0;
    expect_at("resume", 1, 32'h0, 32'h4, 1, 0, 0, 0, 0, 0);
    tick();
    tick();
    tick();
    if (expq.size() != 0 || irq.size() != 0) begin
      n_chk++;
      $display("FAIL drain: pending exp=%0d ir=%0d want 0",
               expq.size(), irq.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
